conv_stream_engine: RTL and testbench

Streaming 2-D convolution layer engine, the parametrised successor to the fixed convolution layer. It accepts one pixel per cycle under a valid qualifier and holds a KH x KW sliding window in line buffers. NUM_TREES kernels run in parallel against that one window through pipelined signed multiply-adder trees. Only windows lying fully inside the image are emitted, each with a valid and an end-of-frame flag. It sits between the pixel source and the activation/pooling stage of each conv layer.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_stream_engine_if.sv | 27 ++
 rtl/conv_window.sv | 107 ++++++++++
 rtl/conv_stream_engine.sv | 121 ++++++++++++
 tb/tb_conv_stream_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution engine: log2 sizing, tree depth
// and bus slice offsets.
package conv_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Multiplier register plus one register per pairwise adder level.
    function automatic int unsigned ma_lat(input int unsigned kh, input int unsigned kw);
        return 1 + clog2(kh * kw);
    endfunction

    // Nodes alive at adder level l when n leaves are reduced pairwise (odd one passes).
    function automatic int unsigned level_count(input int unsigned n, input int unsigned l);
        return (n + (1 << l) - 1) >> l;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/conv_stream_engine_if.sv
// Pixel/kernel input and result output bundle of the convolution engine.
interface conv_stream_engine_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned NUM_TREES = 4,
    parameter int unsigned KW        = 3,
    parameter int unsigned KH        = 3
);
    logic [DATA_W-1:0]                pixel_in;
    logic                             pixel_valid;
    logic                             frame_start;
    logic [DATA_W*NUM_TREES*KH*KW-1:0] kernel_in;
    logic                             kernel_load;
    logic [ACC_W*NUM_TREES-1:0]       pixel_out;
    logic                             out_valid;
    logic                             out_last;

    modport master (
        output pixel_in, pixel_valid, frame_start, kernel_in, kernel_load,
        input  pixel_out, out_valid, out_last
    );

    modport slave (
        input  pixel_in, pixel_valid, frame_start, kernel_in, kernel_load,
        output pixel_out, out_valid, out_last
    );
endinterface

// File: rtl/conv_window.sv
// Line buffers, KH x KW sliding window and raster counters; flags windows that
// lie fully inside the image and the final window of a frame.
module conv_window
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KW     = 3,
    parameter int unsigned KH     = 3,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         pixel_in,
    input  logic                      pixel_valid,
    input  logic                      frame_start,
    output logic [DATA_W*KH*KW-1:0]   window,
    output logic                      win_valid,
    output logic                      win_last
);
    localparam int unsigned COL_W = (IMG_W > 1) ? clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? clog2(IMG_H) : 1;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

    localparam col_t COL_LAST = col_t'(IMG_W - 1);
    localparam row_t ROW_LAST = row_t'(IMG_H - 1);
    localparam col_t COL_MIN  = col_t'(KW - 1);
    localparam row_t ROW_MIN  = row_t'(KH - 1);

    col_t col_q, col_d, pos_col;
    row_t row_q, row_d, pos_row;
    logic in_window;

    // lb_q[0] holds the previous row, lb_q[KH-2] the oldest retained row.
    logic [DATA_W-1:0] lb_q  [KH-1][IMG_W];
    logic [DATA_W-1:0] win_q [KH][KW];

    always_comb begin
        pos_col = frame_start ? '0 : col_q;
        pos_row = frame_start ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pixel_valid) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
        end
    end

    assign in_window = (pos_col >= COL_MIN) && (pos_row >= ROW_MIN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q     <= '0;
            row_q     <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int k = 0; k < KH - 1; k++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    lb_q[k][c] <= '0;
                end
            end
            for (int r = 0; r < KH; r++) begin
                for (int c = 0; c < KW; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            win_valid <= pixel_valid && in_window;
            win_last  <= pixel_valid && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            if (pixel_valid) begin
                lb_q[0][pos_col] <= pixel_in;
                for (int k = 1; k < KH - 1; k++) begin
                    lb_q[k][pos_col] <= lb_q[k-1][pos_col];
                end
                for (int r = 0; r < KH; r++) begin
                    for (int c = 0; c < KW - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                end
                // Newest column: oldest row on top, incoming pixel at the bottom.
                for (int r = 0; r < KH - 1; r++) begin
                    win_q[r][KW-1] <= lb_q[KH-2-r][pos_col];
                end
                win_q[KH-1][KW-1] <= pixel_in;
            end
        end
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < KH; r++) begin
            for (int c = 0; c < KW; c++) begin
                window[(r*KW+c)*DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming 2-D convolution: one window per accepted pixel fed to NUM_TREES
// pipelined signed multiply-adder trees sharing that window.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned NUM_TREES = 4,
    parameter int unsigned KW        = 3,
    parameter int unsigned KH        = 3,
    parameter int unsigned IMG_W     = 28,
    parameter int unsigned IMG_H     = 28
) (
    input logic                 clock,
    input logic                 reset,
    conv_stream_engine_if.slave bus
);
    localparam int unsigned TAPS   = KH * KW;
    localparam int unsigned MA_LAT = ma_lat(KH, KW);
    localparam int unsigned KV_W   = DATA_W * NUM_TREES * TAPS;

    logic [DATA_W*TAPS-1:0] window;
    logic                   win_valid;
    logic                   win_last;

    conv_window #(
        .DATA_W (DATA_W),
        .KW     (KW),
        .KH     (KH),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) u_window (
        .clock       (clock),
        .reset       (reset),
        .pixel_in    (bus.pixel_in),
        .pixel_valid (bus.pixel_valid),
        .frame_start (bus.frame_start),
        .window      (window),
        .win_valid   (win_valid),
        .win_last    (win_last)
    );

    // kernel_q captures the load; weight_q goes live one edge later so a window
    // completed on the load cycle still multiplies with the previous weights.
    logic [KV_W-1:0] kernel_q, weight_q;
    logic            load_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kernel_q <= '0;
            weight_q <= '0;
            load_q   <= 1'b0;
        end else begin
            load_q <= bus.kernel_load;
            if (bus.kernel_load) kernel_q <= bus.kernel_in;
            if (load_q)          weight_q <= kernel_q;
        end
    end

    logic [MA_LAT-1:0] vld_q, lst_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[MA_LAT-2:0], win_valid};
            lst_q <= {lst_q[MA_LAT-2:0], win_last};
        end
    end

    for (genvar t = 0; t < NUM_TREES; t++) begin : g_tree
        localparam int unsigned WBASE = slice_lo(t, TAPS * DATA_W);

        logic signed [2*DATA_W-1:0] prod   [TAPS];
        logic signed [ACC_W-1:0]    node_q [MA_LAT][TAPS];

        always_comb begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                prod[i] = $signed(window[i*DATA_W +: DATA_W]) *
                          $signed(weight_q[WBASE + i*DATA_W +: DATA_W]);
            end
        end

        // Stages load only on valid, so the final node holds between results.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int unsigned l = 0; l < MA_LAT; l++) begin
                    for (int unsigned i = 0; i < TAPS; i++) begin
                        node_q[l][i] <= '0;
                    end
                end
            end else begin
                if (win_valid) begin
                    for (int unsigned i = 0; i < TAPS; i++) begin
                        node_q[0][i] <= {{(ACC_W-2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
                    end
                end
                for (int unsigned l = 1; l < MA_LAT; l++) begin
                    if (vld_q[l-1]) begin
                        for (int unsigned i = 0; i < TAPS; i++) begin
                            if (2*i + 1 < level_count(TAPS, l - 1)) begin
                                node_q[l][i] <= node_q[l-1][2*i] + node_q[l-1][2*i+1];
                            end else if (2*i < level_count(TAPS, l - 1)) begin
                                node_q[l][i] <= node_q[l-1][2*i];
                            end else begin
                                node_q[l][i] <= '0;
                            end
                        end
                    end
                end
            end
        end

        assign bus.pixel_out[slice_lo(t, ACC_W) +: ACC_W] = node_q[MA_LAT-1][0];
    end

    assign bus.out_valid = vld_q[MA_LAT-1];
    assign bus.out_last  = lst_q[MA_LAT-1];

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: table-driven uniform frames plus randomized
// frames scored against an image-array convolution model.
module tb_conv_stream_engine;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned NUM_TREES = 4;
    localparam int unsigned KW        = 3;
    localparam int unsigned KH        = 3;
    localparam int unsigned IMG_W     = 28;
    localparam int unsigned IMG_H     = 28;
    localparam int unsigned TAPS      = KH * KW;
    localparam int unsigned KV_W      = DATA_W * NUM_TREES * TAPS;
    localparam int unsigned PO_W      = ACC_W * NUM_TREES;
    localparam int          NPIX      = IMG_W * IMG_H;
    localparam int          FRAME_OUT = (IMG_W - KW + 1) * (IMG_H - KH + 1);
    localparam int          LATENCY   = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    conv_stream_engine_if #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .NUM_TREES (NUM_TREES),
        .KW        (KW),
        .KH        (KH)
    ) bus ();

    conv_stream_engine #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .NUM_TREES (NUM_TREES),
        .KW        (KW),
        .KH        (KH),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [PO_W-1:0] data;
        bit              last;
        int              cyc;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] pix;
        logic [DATA_W-1:0] wt;
        int                res;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   passed    = 0;
    int   cycle_cnt = 0;
    int   out_cnt   = 0;
    int   last_cnt  = 0;
    int   mr        = 0;
    int   mc        = 0;

    logic signed [DATA_W-1:0] img [IMG_H][IMG_W];
    logic [KV_W-1:0]          model_w = '0;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [PO_W-1:0] act,
                         input logic [PO_W-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Reference: direct convolution of the stored frame at the window ending at (mr, mc).
    task automatic push_expected();
        exp_t   e;
        longint s;
        e.data = '0;
        for (int t = 0; t < NUM_TREES; t++) begin
            s = 0;
            for (int kr = 0; kr < KH; kr++) begin
                for (int kc = 0; kc < KW; kc++) begin
                    s += longint'(img[mr-KH+1+kr][mc-KW+1+kc]) *
                         longint'($signed(model_w[(t*TAPS + kr*KW + kc)*DATA_W +: DATA_W]));
                end
            end
            e.data[t*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        e.last = (mr == IMG_H - 1) && (mc == IMG_W - 1);
        e.cyc  = cycle_cnt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] p, input bit fs,
                         input bit ld, input logic [KV_W-1:0] kv);
        bus.pixel_valid = v;
        bus.pixel_in    = p;
        bus.frame_start = fs;
        bus.kernel_load = ld;
        bus.kernel_in   = kv;
        if (v) begin
            if (fs) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            if (mr >= KH - 1 && mc >= KW - 1) push_expected();
            if (mc == IMG_W - 1) begin
                mc = 0;
                mr = (mr == IMG_H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        // Loads only affect windows completed on later cycles.
        if (ld) model_w = kv;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, bus.kernel_in);
    endtask

    task automatic load_weights(input logic [KV_W-1:0] kv);
        drive(1'b0, '0, 1'b0, 1'b1, kv);
    endtask

    function automatic logic [KV_W-1:0] rand_kv();
        logic [KV_W-1:0] kv;
        for (int j = 0; j < KV_W / 32; j++) kv[j*32 +: 32] = $urandom;
        return kv;
    endfunction

    // mode 0: constant, 1: ramp, 2: random; gap cycles carry a stray frame_start.
    task automatic run_frame(input int mode, input logic [DATA_W-1:0] cval, input int gap_pct,
                             input int n_pix, input int load_at,
                             input logic [KV_W-1:0] load_vec);
        logic [DATA_W-1:0] p;
        for (int i = 0; i < n_pix; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                drive(1'b0, DATA_W'($urandom), 1'($urandom_range(1)), 1'b0, bus.kernel_in);
            end
            case (mode)
                0:       p = cval;
                1:       p = DATA_W'(i % 128);
                default: p = DATA_W'($urandom);
            endcase
            drive(1'b1, p, i == 0, i == load_at, (i == load_at) ? load_vec : bus.kernel_in);
        end
    endtask

    task automatic drain_and_count(input string name, input int n_out, input int n_last);
        idle(12);
        check({name, "_drain"}, PO_W'(exp_q.size()), PO_W'(0));
        check({name, "_count"}, PO_W'(out_cnt), PO_W'(n_out));
        check({name, "_last"}, PO_W'(last_cnt), PO_W'(n_last));
        out_cnt  = 0;
        last_cnt = 0;
    endtask

    always @(negedge clock) begin
        if (reset && bus.out_valid === 1'b1) begin
            out_cnt++;
            if (bus.out_last === 1'b1) last_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", PO_W'(1), PO_W'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("pixel_out", bus.pixel_out, mon_e.data);
                check("out_last", PO_W'(bus.out_last), PO_W'(mon_e.last));
                check("latency", PO_W'(cycle_cnt - mon_e.cyc), PO_W'(LATENCY));
            end
        end
    end

    vec_t            vecs [5];
    logic [ACC_W-1:0] rv;
    logic [KV_W-1:0]  kv;

    initial begin
        vecs[0] = '{8'h01, 8'h01, 9};
        vecs[1] = '{8'h80, 8'h80, 147456};
        vecs[2] = '{8'h80, 8'h7f, -146304};
        vecs[3] = '{8'h05, 8'hfd, -135};
        vecs[4] = '{8'h7f, 8'h7f, 145161};

        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        bus.frame_start = 1'b0;
        bus.kernel_in   = '0;
        bus.kernel_load = 1'b0;

        #1 reset = 1'b0;
        #2;
        check("reset_out_valid", PO_W'(bus.out_valid), PO_W'(0));
        check("reset_out_last", PO_W'(bus.out_last), PO_W'(0));
        check("reset_pixel_out", bus.pixel_out, PO_W'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        // Uniform frames: every window gives the tabulated value on all trees.
        for (int v = 0; v < 5; v++) begin
            load_weights({(NUM_TREES*TAPS){vecs[v].wt}});
            run_frame(0, vecs[v].pix, 0, NPIX, -1, '0);
            drain_and_count("uniform", FRAME_OUT, 1);
            rv = ACC_W'(vecs[v].res);
            check("uniform_hold_valid", PO_W'(bus.out_valid), PO_W'(0));
            for (int t = 0; t < NUM_TREES; t++) begin
                check("uniform_value", PO_W'(bus.pixel_out[t*ACC_W +: ACC_W]), PO_W'(rv));
            end
        end

        // Ramp with tree 0 as a centre-tap identity, other trees random.
        kv = rand_kv();
        for (int i = 0; i < TAPS; i++) kv[i*DATA_W +: DATA_W] = (i == TAPS / 2) ? 8'h01 : 8'h00;
        load_weights(kv);
        run_frame(1, '0, 0, NPIX, -1, '0);
        drain_and_count("ramp", FRAME_OUT, 1);

        // Random pixels with ~50% valid gaps.
        load_weights(rand_kv());
        run_frame(2, '0, 50, NPIX, -1, '0);
        drain_and_count("gaps", FRAME_OUT, 1);

        // Weights 1 -> 2 loaded together with the pixel completing window (14, 8).
        load_weights({(NUM_TREES*TAPS){8'h01}});
        run_frame(2, '0, 0, NPIX, 14 * IMG_W + 8, {(NUM_TREES*TAPS){8'h02}});
        drain_and_count("midload", FRAME_OUT, 1);

        // Truncated frame (300 pixels -> 8*26 + 18 windows) followed by a full one.
        load_weights(rand_kv());
        run_frame(2, '0, 20, 300, -1, '0);
        run_frame(2, '0, 20, NPIX, -1, '0);
        drain_and_count("truncate", 226 + FRAME_OUT, 1);

        // Asynchronous reset with the pipeline full.
        load_weights(rand_kv());
        run_frame(2, '0, 0, 400, -1, '0);
        check("prereset_valid", PO_W'(bus.out_valid), PO_W'(1));
        reset = 1'b0;
        #1;
        check("midreset_out_valid", PO_W'(bus.out_valid), PO_W'(0));
        check("midreset_out_last", PO_W'(bus.out_last), PO_W'(0));
        check("midreset_pixel_out", bus.pixel_out, PO_W'(0));
        exp_q.delete();
        model_w  = '0;
        mr       = 0;
        mc       = 0;
        out_cnt  = 0;
        last_cnt = 0;
        idle(3);
        reset = 1'b1;
        idle(1);
        load_weights(rand_kv());
        run_frame(2, '0, 0, NPIX, -1, '0);
        drain_and_count("postreset", FRAME_OUT, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
